// File: rtl/axi_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_arbiter_pkg
// Description : Shared AXI read-channel widths, burst encoding and the
//               arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_read_arbiter_pkg;

    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_LEN_W   = 4;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    // Width of the grant index prepended to the master ID on the slave side.
    localparam int ARB_IDX_W   = 4;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    // Index width for a master count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_arbiter_if
// Description : Read-address / read-data bundle between NUM_M masters, the
//               arbiter and a single shared slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_read_arbiter_if #(
    parameter int NUM_M = 2,
    parameter int MID_W = 4
);
    import axi_read_arbiter_pkg::*;

    localparam int SID_W = MID_W + ARB_IDX_W;

    // Master-side address channel
    logic [MID_W-1:0]       ARID_M    [NUM_M];
    logic [AXI_ADDR_W-1:0]  ARADDR_M  [NUM_M];
    logic [AXI_LEN_W-1:0]   ARLEN_M   [NUM_M];
    logic [AXI_SIZE_W-1:0]  ARSIZE_M  [NUM_M];
    logic [AXI_BURST_W-1:0] ARBURST_M [NUM_M];
    logic [NUM_M-1:0]       ARVALID_M;
    logic [NUM_M-1:0]       ARREADY_M;

    // Master-side read data channel
    logic [MID_W-1:0]       RID_M     [NUM_M];
    logic [AXI_DATA_W-1:0]  RDATA_M   [NUM_M];
    logic [AXI_RESP_W-1:0]  RRESP_M   [NUM_M];
    logic [NUM_M-1:0]       RLAST_M;
    logic [NUM_M-1:0]       RVALID_M;
    logic [NUM_M-1:0]       RREADY_M;

    // Slave-side channels
    logic [SID_W-1:0]       ARID_S;
    logic [AXI_ADDR_W-1:0]  ARADDR_S;
    logic [AXI_LEN_W-1:0]   ARLEN_S;
    logic [AXI_SIZE_W-1:0]  ARSIZE_S;
    logic [AXI_BURST_W-1:0] ARBURST_S;
    logic                   ARVALID_S;
    logic                   ARREADY_S;
    logic [SID_W-1:0]       RID_S;
    logic [AXI_DATA_W-1:0]  RDATA_S;
    logic [AXI_RESP_W-1:0]  RRESP_S;
    logic                   RLAST_S;
    logic                   RVALID_S;
    logic                   RREADY_S;

    // View of the upstream read masters
    modport master (
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
        input  ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
    );

    // View of the downstream shared slave
    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );

    // View of the arbiter sitting between them
    modport arb (
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
        output ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );

endinterface
`default_nettype wire

// File: rtl/axi_read_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_arbiter_arb_pick
// Description : Grant selection: request vector (+ pointer) -> one-hot grant.
//               ARB_ROUND_ROBIN_EN defined : round-robin from the pointer.
//               ARB_ROUND_ROBIN_EN undefined: fixed priority, highest index
//               wins, no pointer input.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_read_arbiter_arb_pick #(
    parameter int NUM_M = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM_M-1:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [NUM_M-1:0] gnt_o
);

`ifdef ARB_ROUND_ROBIN_EN
    logic found;

    // Scan upward from the pointer with wrap-around; first requester wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % NUM_M]) begin
                gnt_o[(int'(ptr_i) + k) % NUM_M] = 1'b1;
                found = 1'b1;
            end
        end
    end
`else
    // Later (higher-index) requesters overwrite earlier ones: highest wins.
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_arbiter
// Description : Single-outstanding AXI read arbiter, NUM_M masters onto one
//               slave. IDLE -> ADDR -> DATA; grant held until RLAST retires.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration; default is fixed priority (highest index first).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int MID_W = 4
) (
    input  logic            clk,
    input  logic            rstn,
    axi_read_arbiter_if.arb bus_if,
    output logic            busy
);

    localparam int IDX_W = idx_width(NUM_M);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] pick_idx;
    logic [NUM_M-1:0] pick_oh;
    logic             ar_hs;
    logic             r_last_hs;
    logic             unused_rid_hi;

    // Upper RID bits carry our own grant index; routing uses grant_q instead.
    assign unused_rid_hi = ^bus_if.RID_S[MID_W+ARB_IDX_W-1:MID_W];

    assign ar_hs     = (state_q == ST_ADDR) && bus_if.ARREADY_S;
    assign r_last_hs = (state_q == ST_DATA) && bus_if.RVALID_S
                       && bus_if.RREADY_M[grant_q] && bus_if.RLAST_S;
    assign busy      = (state_q != ST_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Pointer moves to the master after the one just accepted by the slave.
    always_comb begin
        ptr_d = ptr_q;
        if (ar_hs) begin
            ptr_d = (grant_q == IDX_W'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    // Round-robin pointer register; M0 has first turn after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    axi_read_arbiter_arb_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_arb_pick (
        .req_i (bus_if.ARVALID_M),
`ifdef ARB_ROUND_ROBIN_EN
        .ptr_i (ptr_q),
`endif
        .gnt_o (pick_oh)
    );

    // Convert the one-hot pick into a master index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (pick_oh[i]) pick_idx = IDX_W'(i);
        end
    end

    // State and grant registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next-state: grant is captured only when leaving IDLE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus_if.ARVALID_M) begin
                    grant_d = pick_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: if (ar_hs)     state_d = ST_DATA;
            ST_DATA: if (r_last_hs) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Channel muxing: AR from the granted master, R back to it only.
    always_comb begin
        bus_if.ARVALID_S = (state_q == ST_ADDR);
        bus_if.ARID_S    = {ARB_IDX_W'(grant_q), bus_if.ARID_M[grant_q]};
        bus_if.ARADDR_S  = bus_if.ARADDR_M[grant_q];
        bus_if.ARLEN_S   = bus_if.ARLEN_M[grant_q];
        bus_if.ARSIZE_S  = bus_if.ARSIZE_M[grant_q];
        bus_if.ARBURST_S = bus_if.ARBURST_M[grant_q];
        bus_if.RREADY_S  = (state_q == ST_DATA) && bus_if.RREADY_M[grant_q];
        bus_if.ARREADY_M = '0;
        bus_if.RVALID_M  = '0;
        bus_if.RLAST_M   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            bus_if.ARREADY_M[i] = (state_q == ST_ADDR) && (grant_q == IDX_W'(i))
                                  && bus_if.ARREADY_S;
            bus_if.RVALID_M[i]  = (state_q == ST_DATA) && (grant_q == IDX_W'(i))
                                  && bus_if.RVALID_S;
            bus_if.RLAST_M[i]   = bus_if.RLAST_S;
            bus_if.RID_M[i]     = bus_if.RID_S[MID_W-1:0];
            bus_if.RDATA_M[i]   = bus_if.RDATA_S;
            bus_if.RRESP_M[i]   = bus_if.RRESP_S;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_read_arbiter
// Description : Self-checking bench for axi_read_arbiter with randomized
//               transactions and a queue-free arbitration reference model.
//               Follows ARB_ROUND_ROBIN_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int NUM_M = 2;
    localparam int MID_W = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy;
    int   total = 0;
    int   bad   = 0;
    int   model_ptr = 0;   // whose turn it is under round-robin

    axi_read_arbiter_if #(.NUM_M(NUM_M), .MID_W(MID_W)) bus ();

    axi_read_arbiter #(.NUM_M(NUM_M), .MID_W(MID_W)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_if (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference arbitration: who should win given the request set.
    function automatic int model_pick(input logic [1:0] req);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 2; k++) begin
            if (req[(model_ptr + k) % 2]) return (model_ptr + k) % 2;
        end
        return 0;
`else
        if (req[1]) return 1;
        return 0;
`endif
    endfunction

    // One full transaction starting in IDLE at posedge+1; returns the winner.
    task automatic run_txn(input logic [1:0] req, input int len, input int stall,
                           input bit gaps, input bit directed, output int win);
        logic [3:0]  id    [2];
        logic [31:0] addr  [2];
        logic [3:0]  alen  [2];
        logic [2:0]  asize [2];
        logic [1:0]  exp_ardy;
        int beats, done, cyc;
        for (int m = 0; m < 2; m++) begin
            id[m]    = directed ? 4'h0 : 4'($urandom_range(0, 15));
            addr[m]  = directed ? 32'h0000_0100 : $urandom;
            alen[m]  = (len >= 0) ? 4'(len) : 4'($urandom_range(0, 7));
            asize[m] = 3'($urandom_range(0, 2));
            bus.ARID_M[m]    = id[m];
            bus.ARADDR_M[m]  = addr[m];
            bus.ARLEN_M[m]   = alen[m];
            bus.ARSIZE_M[m]  = asize[m];
            bus.ARBURST_M[m] = AXI_BURST_INCR;
        end
        bus.RVALID_S  = 1'b0;
        bus.RLAST_S   = 1'b0;
        bus.ARREADY_S = 1'b0;
        bus.ARVALID_M = req;
        win = model_pick(req);
        #1;
        total++;
        if (busy !== 1'b0 || bus.ARVALID_S !== 1'b0) begin
            bad++;
            $display("FAIL idle_before_grant: busy=%b arvalid_s=%b, required 0 0", busy, bus.ARVALID_S);
        end
        @(posedge clk); #1;
        // Address phase, optionally stalled by the slave.
        for (int c = 0; c <= stall; c++) begin
            bus.ARREADY_S = (c == stall);
            #1;
            total++;
            if (bus.ARVALID_S !== 1'b1 || bus.ARID_S !== {4'(win), id[win]} || bus.ARADDR_S !== addr[win]
                || bus.ARLEN_S !== alen[win] || bus.ARSIZE_S !== asize[win] || bus.ARBURST_S !== AXI_BURST_INCR) begin
                bad++;
                $display("FAIL ar_payload: cyc=%0d valid=%b id=%h addr=%h len=%0d, required 1 %h %h %0d (master %0d)",
                         c, bus.ARVALID_S, bus.ARID_S, bus.ARADDR_S, bus.ARLEN_S, {4'(win), id[win]}, addr[win], alen[win], win);
            end
            exp_ardy = (c == stall) ? (2'b01 << win) : 2'b00;
            total++;
            if (bus.ARREADY_M !== exp_ardy) begin
                bad++;
                $display("FAIL ar_ready_route: cyc=%0d got=%b required=%b", c, bus.ARREADY_M, exp_ardy);
            end
            total++;
            if (busy !== 1'b1 || bus.RREADY_S !== 1'b0 || bus.RVALID_M !== 2'b00) begin
                bad++;
                $display("FAIL addr_phase_state: busy=%b rready_s=%b rvalid_m=%b, required 1 0 00", busy, bus.RREADY_S, bus.RVALID_M);
            end
            @(posedge clk); #1;
        end
        bus.ARREADY_S      = 1'b0;
        bus.ARVALID_M[win] = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        model_ptr = (win + 1) % 2;
`endif
        // Data phase: random slave gaps, random master back-pressure.
        beats = int'(alen[win]) + 1;
        done  = 0;
        cyc   = 0;
        while (done < beats && cyc < 300) begin
            bus.RVALID_S = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.RLAST_S  = bus.RVALID_S && (done == beats - 1);
            bus.RDATA_S  = $urandom;
            bus.RRESP_S  = 2'($urandom_range(0, 3));
            bus.RID_S    = {4'(win), id[win]};
            bus.RREADY_M[win]     = ($urandom_range(0, 3) != 0);
            bus.RREADY_M[1 - win] = 1'($urandom_range(0, 1));
            bus.ARVALID_M[1 - win] = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (bus.RVALID_M !== (2'(bus.RVALID_S) << win)) begin
                bad++;
                $display("FAIL r_valid_route: got=%b required=%b (master %0d)", bus.RVALID_M, 2'(bus.RVALID_S) << win, win);
            end
            total++;
            if (bus.RREADY_S !== bus.RREADY_M[win]) begin
                bad++;
                $display("FAIL r_ready_route: got=%b required=%b", bus.RREADY_S, bus.RREADY_M[win]);
            end
            if (bus.RVALID_S) begin
                total++;
                if (bus.RDATA_M[win] !== bus.RDATA_S || bus.RID_M[win] !== id[win]
                    || bus.RRESP_M[win] !== bus.RRESP_S || bus.RLAST_M[win] !== bus.RLAST_S) begin
                    bad++;
                    $display("FAIL r_payload: data=%h id=%h resp=%b last=%b, required %h %h %b %b",
                             bus.RDATA_M[win], bus.RID_M[win], bus.RRESP_M[win], bus.RLAST_M[win],
                             bus.RDATA_S, id[win], bus.RRESP_S, bus.RLAST_S);
                end
            end
            total++;
            if (busy !== 1'b1 || bus.ARVALID_S !== 1'b0 || bus.ARREADY_M !== 2'b00) begin
                bad++;
                $display("FAIL data_phase_state: busy=%b arvalid_s=%b arready_m=%b, required 1 0 00", busy, bus.ARVALID_S, bus.ARREADY_M);
            end
            if (bus.RVALID_S && bus.RREADY_M[win]) done++;
            cyc++;
            @(posedge clk); #1;
        end
        if (done < beats) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: beats=%0d required=%0d", done, beats);
        end
        // Back in IDLE: a stray slave beat must be neither accepted nor forwarded.
        bus.ARVALID_M = '0;
        bus.RVALID_S  = 1'b1;
        bus.RLAST_S   = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || bus.RREADY_S !== 1'b0 || bus.RVALID_M !== 2'b00) begin
            bad++;
            $display("FAIL retire_idle: busy=%b rready_s=%b rvalid_m=%b, required 0 0 00", busy, bus.RREADY_S, bus.RVALID_M);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int m = 0; m < 2; m++) begin
            bus.ARID_M[m] = '0; bus.ARADDR_M[m] = '0; bus.ARLEN_M[m] = '0;
            bus.ARSIZE_M[m] = '0; bus.ARBURST_M[m] = '0;
        end
        bus.ARVALID_M = 2'b11;   // requests during reset must not be granted
        bus.RREADY_M  = 2'b11;
        bus.ARREADY_S = 1'b1;
        bus.RID_S = '0; bus.RDATA_S = '0; bus.RRESP_S = '0; bus.RLAST_S = 1'b0;
        bus.RVALID_S  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b required=0", busy); end
        total++; if (bus.ARVALID_S !== 1'b0) begin bad++; $display("FAIL reset_arvalid_s: got=%b required=0", bus.ARVALID_S); end
        total++; if (bus.ARREADY_M !== 2'b00) begin bad++; $display("FAIL reset_arready_m: got=%b required=00", bus.ARREADY_M); end
        total++; if (bus.RVALID_M !== 2'b00) begin bad++; $display("FAIL reset_rvalid_m: got=%b required=00", bus.RVALID_M); end
        total++; if (bus.RREADY_S !== 1'b0) begin bad++; $display("FAIL reset_rready_s: got=%b required=0", bus.RREADY_S); end
        rstn = 1'b1;
        bus.ARVALID_M = '0;
        bus.RVALID_S  = 1'b0;
        bus.ARREADY_S = 1'b0;
        model_ptr = 0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_request: busy=%b required=0", busy); end
    endtask

    task automatic test_single_m0();
        int w;
        run_txn(2'b01, 0, 0, 1'b0, 1'b1, w);
        total++; if (w != 0) begin bad++; $display("FAIL single_m0_grant: got=%0d required=0", w); end
    endtask

    task automatic test_burst_gaps();
        int w;
        run_txn(2'b10, 3, 0, 1'b1, 1'b0, w);
        total++; if (w != 1) begin bad++; $display("FAIL burst_m1_grant: got=%0d required=1", w); end
    endtask

    task automatic test_back_to_back();
        int w;
        int exp_order [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{1, 1, 1};
`endif
        for (int t = 0; t < 3; t++) begin
            run_txn(2'b11, -1, 0, 1'b0, 1'b0, w);
            total++;
            if (w != exp_order[t]) begin bad++; $display("FAIL b2b_order[%0d]: got=%0d required=%0d", t, w, exp_order[t]); end
        end
    endtask

    task automatic test_ar_stall();
        int w;
        run_txn(2'b01, -1, 5, 1'b0, 1'b0, w);
    endtask

    task automatic test_reset_midburst();
        int w;
        int exp_w;
        bus.ARID_M[0] = 4'h5; bus.ARADDR_M[0] = $urandom; bus.ARLEN_M[0] = 4'd3;
        bus.ARSIZE_M[0] = 3'd2; bus.ARBURST_M[0] = AXI_BURST_INCR;
        bus.ARVALID_M = 2'b01;
        bus.RREADY_M  = 2'b11;
        bus.RVALID_S  = 1'b0;
        @(posedge clk); #1;
        bus.ARREADY_S = 1'b1;
        @(posedge clk); #1;
        bus.ARREADY_S = 1'b0;
        bus.ARVALID_M = '0;
        bus.RVALID_S  = 1'b1;
        bus.RLAST_S   = 1'b0;
        bus.RID_S     = 8'h05;
        bus.RDATA_S   = $urandom;
        @(posedge clk); #1;      // beat 1 taken, beat 2 now on the bus
        bus.RDATA_S   = $urandom;
        #1;
        total++;
        if (bus.RVALID_M !== 2'b01) begin bad++; $display("FAIL pre_reset_beat2: got=%b required=01", bus.RVALID_M); end
        rstn = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || bus.RVALID_M !== 2'b00 || bus.RREADY_S !== 1'b0
            || bus.ARVALID_S !== 1'b0 || bus.ARREADY_M !== 2'b00) begin
            bad++;
            $display("FAIL async_reset_outputs: busy=%b rvalid_m=%b rready_s=%b arvalid_s=%b arready_m=%b, required all 0",
                     busy, bus.RVALID_M, bus.RREADY_S, bus.ARVALID_S, bus.ARREADY_M);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        model_ptr = 0;
        for (int c = 0; c < 4; c++) begin
            bus.RDATA_S = $urandom;
            bus.RLAST_S = (c == 2);
            #1;
            total++;
            if (busy !== 1'b0 || bus.RVALID_M !== 2'b00 || bus.RREADY_S !== 1'b0) begin
                bad++;
                $display("FAIL stray_beat[%0d]: busy=%b rvalid_m=%b rready_s=%b, required 0 00 0", c, busy, bus.RVALID_M, bus.RREADY_S);
            end
            @(posedge clk); #1;
        end
        bus.RVALID_S = 1'b0;
        bus.RLAST_S  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_w = 0;
`else
        exp_w = 1;
`endif
        run_txn(2'b11, -1, 0, 1'b0, 1'b0, w);
        total++;
        if (w != exp_w) begin bad++; $display("FAIL post_reset_grant: got=%0d required=%0d", w, exp_w); end
    endtask

    task automatic test_random();
        int w;
        for (int t = 0; t < 20; t++) begin
            run_txn(2'($urandom_range(1, 3)), -1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, w);
        end
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_burst_gaps();
        test_back_to_back();
        test_ar_stall();
        test_reset_midburst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
